mem_bus_port: RTL and testbench

//  Bus-side memory port of the single-bus datapath. Loads MAR and MDR from the shared bus
//  (BusMuxOut). Runs one read or write transaction per request against the memory
//  req/ack handshake. Drives the MDR contents back as BusMuxInMDR for the bus mux.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/mem_bus_port_if.sv | 32 +++
 rtl/mem_bus_port_mdr_reg.sv | 33 +++
 rtl/mem_bus_port.sv | 137 +++++++++++++
 tb/tb_mem_bus_port.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the bus-side memory port.
//   WORD_W       datapath / bus word width
//   DEF_ADDR_W   default MAR width
//   mem_state_t  memory transaction FSM states
package cpu_pkg;

  localparam int WORD_W     = 32;
  localparam int DEF_ADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_bus_port_if.sv
// Memory-side request/acknowledge bundle between mem_bus_port and the memory.
//   mem_addr   port -> memory   word address (MAR)
//   mem_wdata  port -> memory   write data (MDR)
//   mem_req    port -> memory   request active
//   mem_we     port -> memory   1 = write, 0 = read
//   mem_rdata  memory -> port   read data, valid with mem_ack
//   mem_ack    memory -> port   current request complete
// Modports: master (the port), slave (the memory).
interface mem_bus_port_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_req, mem_we,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_req, mem_we,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_bus_port_mdr_reg.sv
// Memory data register with a two-way source select.
//   clock    system clock
//   clear    synchronous active-high reset, clears the register
//   bus_d    value from the shared bus
//   mem_d    value returned by memory
//   sel_mem  1 = load mem_d, 0 = load bus_d
//   en       load enable
//   q        register contents
module mdr_reg
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic [WORD_W-1:0] bus_d,
  input  logic [WORD_W-1:0] mem_d,
  input  logic              sel_mem,
  input  logic              en,
  output logic [WORD_W-1:0] q
);

  logic [WORD_W-1:0] mdr_reg_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      mdr_reg_q <= '0;
    end else if (en) begin
      mdr_reg_q <= sel_mem ? mem_d : bus_d;
    end
  end

  assign q = mdr_reg_q;

endmodule

// File: rtl/mem_bus_port.sv
// Bus-side memory port: MAR/MDR loaded from the shared bus, one read or
// write transaction per start pulse over the memory req/ack handshake,
// MDR driven back to the bus mux.
//   clock, clear           clock and synchronous active-high reset
//   BusMuxOut              shared bus value
//   MARin / MDRin          load MAR / MDR from the bus (idle only)
//   start_read/start_write 1-cycle start pulses (read wins if both)
//   BusMuxInMDR            MDR contents for the bus mux
//   busy / done / err      status; done is a 1-cycle pulse, err flags timeout
//   mem                    memory handshake (mem_bus_port_if.master)
// Optional feature: define MEM_TIMEOUT_EN to abort a request after
// TIMEOUT_CYCLES unacknowledged REQ cycles (err=1 with done).
module mem_bus_port
  import cpu_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic              clock,
  input  logic              clear,
  input  logic [WORD_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              start_read,
  input  logic              start_write,
  output logic [WORD_W-1:0] BusMuxInMDR,
  output logic              busy,
  output logic              done,
  output logic              err,
  mem_bus_port_if.master    mem
);

  mem_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] mar_reg;
  logic              we_reg;
  logic [WORD_W-1:0] mdr_q;
  logic              start;
  logic              idle;
  logic              in_req;
  logic              timeout_hit;
  logic              mdr_en;

  assign start  = start_read | start_write;
  assign idle   = (state_reg == IDLE);
  assign in_req = (state_reg == REQ);

`ifdef MEM_TIMEOUT_EN
  // At least 8 bits, wider only if the limit needs it.
  localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  // Current REQ cycle is the TIMEOUT_CYCLES-th one without an ack.
  assign timeout_hit = in_req && !mem.mem_ack &&
                       (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (in_req && !mem.mem_ack) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else begin
        cnt_reg <= '0;
      end
      // Only set on the abort edge, so it is 1 exactly in the DONE cycle.
      err_reg <= timeout_hit;
    end
  end

  assign err = err_reg;
`else
  // The limit has no effect when requests wait indefinitely.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = REQ;
      REQ:     if (mem.mem_ack || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Loads are suppressed on the start edge so the transaction sees the
  // MAR/MDR values that were present before the start pulse.
  always_ff @(posedge clock) begin
    if (clear) begin
      mar_reg <= '0;
      we_reg  <= 1'b0;
    end else if (idle) begin
      if (start) begin
        we_reg <= start_write & ~start_read;
      end else if (MARin) begin
        mar_reg <= BusMuxOut[ADDR_W-1:0];
      end
    end
  end

  // Memory source only when a read is acknowledged; an aborted read leaves MDR alone.
  assign mdr_en = (idle && MDRin && !start) ||
                  (in_req && mem.mem_ack && !we_reg);

  mdr_reg u_mdr (
    .clock   (clock),
    .clear   (clear),
    .bus_d   (BusMuxOut),
    .mem_d   (mem.mem_rdata),
    .sel_mem (in_req),
    .en      (mdr_en),
    .q       (mdr_q)
  );

  assign mem.mem_addr  = mar_reg;
  assign mem.mem_wdata = mdr_q;
  assign mem.mem_req   = in_req;
  assign mem.mem_we    = we_reg;
  assign BusMuxInMDR   = mdr_q;
  assign busy          = !idle;
  assign done          = (state_reg == DONE);

endmodule

// File: tb/tb_mem_bus_port.sv
// Directed bench for mem_bus_port: reset, read with waits, write, start
// collisions, zero-wait read, ignored acks, and timeout / indefinite wait.
module tb_mem_bus_port;

  logic        clk;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, start_read, start_write;
  logic [31:0] BusMuxInMDR;
  logic        busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_port_if #(.ADDR_W(9)) mbus ();

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  mem_bus_port #(.ADDR_W(9), .TIMEOUT_CYCLES(TMO)) dut (
    .clock       (clk),
    .clear       (clear),
    .BusMuxOut   (BusMuxOut),
    .MARin       (MARin),
    .MDRin       (MDRin),
    .start_read  (start_read),
    .start_write (start_write),
    .BusMuxInMDR (BusMuxInMDR),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mem         (mbus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clear = 1'b1; BusMuxOut = '0; MARin = 0; MDRin = 0;
    start_read = 0; start_write = 0;
    mbus.mem_ack = 0; mbus.mem_rdata = '0;
    step(); step();
    clear = 1'b0;
    chk("reset_req",  {31'd0, mbus.mem_req}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_mdr",  BusMuxInMDR, 32'd0);
    chk("reset_mar",  {23'd0, mbus.mem_addr}, 32'd0);
    chk("reset_done_err", {30'd0, done, err}, 32'd0);
    $display("reset: req=%0b busy=%0b mdr=%h", mbus.mem_req, busy, BusMuxInMDR);

    // Read with 3 wait cycles
    BusMuxOut = 32'h0000_0045; MARin = 1; step(); MARin = 0;
    chk("mar_load", {23'd0, mbus.mem_addr}, 32'h045);
    start_read = 1; step(); start_read = 0;
    chk("rd_req", {30'd0, mbus.mem_req, mbus.mem_we}, 32'b10);
    step(); step(); step();
    chk("rd_req_held", {31'd0, mbus.mem_req}, 32'd1);
    chk("rd_addr", {23'd0, mbus.mem_addr}, 32'h045);
    mbus.mem_ack = 1; mbus.mem_rdata = 32'hDEAD_BEEF; step(); mbus.mem_ack = 0;
    chk("rd_done", {29'd0, done, busy, mbus.mem_req}, 32'b110);
    chk("rd_mdr", BusMuxInMDR, 32'hDEAD_BEEF);
    step();
    chk("rd_idle", {30'd0, done, busy}, 32'd0);
    $display("read: addr=045 data=%h", BusMuxInMDR);

    // Write
    BusMuxOut = 32'h1234_5678; MDRin = 1; step(); MDRin = 0;
    chk("mdr_load", BusMuxInMDR, 32'h1234_5678);
    start_write = 1; step(); start_write = 0;
    chk("wr_we", {30'd0, mbus.mem_req, mbus.mem_we}, 32'b11);
    mbus.mem_rdata = 32'hFFFF_0000; step();
    chk("wr_wdata_held", mbus.mem_wdata, 32'h1234_5678);
    mbus.mem_ack = 1; step(); mbus.mem_ack = 0;
    chk("wr_done", {31'd0, done}, 32'd1);
    chk("wr_mdr_kept", BusMuxInMDR, 32'h1234_5678);
    step();
    $display("write: addr=045 data=%h", mbus.mem_wdata);

    // Collisions
    start_read = 1; start_write = 1; step(); start_read = 0; start_write = 0;
    chk("both_start_we", {30'd0, mbus.mem_req, mbus.mem_we}, 32'b10);
    BusMuxOut = 32'hAAAA_5555; MDRin = 1; MARin = 1; step(); MDRin = 0; MARin = 0;
    chk("busy_mdr_ignored", BusMuxInMDR, 32'h1234_5678);
    chk("busy_mar_ignored", {23'd0, mbus.mem_addr}, 32'h045);
    mbus.mem_ack = 1; mbus.mem_rdata = 32'h0BAD_F00D; step(); mbus.mem_ack = 0;
    chk("coll_done_mdr", BusMuxInMDR, 32'h0BAD_F00D);
    start_read = 1; step(); start_read = 0;
    chk("done_start_ign", {30'd0, busy, mbus.mem_req}, 32'd0);
    step();
    chk("done_start_ign2", {30'd0, busy, mbus.mem_req}, 32'd0);
    $display("collision: mdr=%h busy=%0b", BusMuxInMDR, busy);

    // Zero-wait read; MARin with start keeps old MAR
    BusMuxOut = 32'h0000_01FF; MARin = 1; start_read = 1; step();
    MARin = 0; start_read = 0;
    chk("start_old_mar", {23'd0, mbus.mem_addr}, 32'h045);
    mbus.mem_ack = 1; mbus.mem_rdata = 32'h1111_1111; step(); mbus.mem_ack = 0;
    chk("zw_done", {31'd0, done}, 32'd1);
    chk("zw_mdr", BusMuxInMDR, 32'h1111_1111);
    step();
    $display("zero-wait: data=%h", BusMuxInMDR);

    // Ack while idle is ignored
    mbus.mem_ack = 1; step(); mbus.mem_ack = 0;
    chk("idle_ack_ign", {30'd0, busy, done}, 32'd0);

    // Reset mid-transaction
    start_read = 1; step(); start_read = 0;
    chk("pre_rst_req", {31'd0, mbus.mem_req}, 32'd1);
    clear = 1; step(); clear = 0;
    chk("rst_mid_req", {30'd0, mbus.mem_req, busy}, 32'd0);
    chk("rst_mid_mdr", BusMuxInMDR, 32'd0);
    chk("rst_mid_mar", {23'd0, mbus.mem_addr}, 32'd0);
    mbus.mem_ack = 1; step(); mbus.mem_ack = 0;
    chk("rst_late_ack", {30'd0, busy, done}, 32'd0);
    $display("reset mid-REQ: req=%0b busy=%0b", mbus.mem_req, busy);

    // Timeout / indefinite wait
    BusMuxOut = 32'hCAFE_0001; MDRin = 1; step(); MDRin = 0;
    start_read = 1; step(); start_read = 0;
`ifdef MEM_TIMEOUT_EN
    step(); step(); step();
    chk("tmo_req_cycle4", {31'd0, mbus.mem_req}, 32'd1);
    step();
    chk("tmo_done_err", {29'd0, done, err, mbus.mem_req}, 32'b110);
    chk("tmo_mdr_kept", BusMuxInMDR, 32'hCAFE_0001);
    step();
    chk("tmo_err_clear", {30'd0, done, err}, 32'd0);
    $display("timeout: err asserted after %0d REQ cycles", TMO);
`else
    begin
      int drops = 0;
      for (int i = 0; i < 1000; i++) begin
        step();
        if (mbus.mem_req !== 1'b1 || done !== 1'b0) drops++;
      end
      chk("req_held_1000", drops, 32'd0);
    end
    mbus.mem_ack = 1; mbus.mem_rdata = 32'h2222_2222; step(); mbus.mem_ack = 0;
    chk("late_ack_done", {30'd0, done, err}, 32'b10);
    chk("late_ack_mdr", BusMuxInMDR, 32'h2222_2222);
    step();
    $display("no timeout: REQ held 1000 cycles, data=%h", BusMuxInMDR);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
